// File: rtl/spi_pkg.sv
// Shared definitions for the SPI secondary (receive and transmit) blocks.
package spi_pkg;

  // Default number of bits per SPI word.
  localparam int SPI_WORD_WIDTH = 8;

  // Flip-flops in each pin synchronizer chain.
  localparam int SPI_SYNC_STAGES = 2;

  // Transmitter framing state: IDLE while cs is high, ACTIVE while a frame is open.
  typedef enum logic {
    IDLE,
    ACTIVE
  } tx_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings one asynchronous SPI pin into the clk domain and flags its edges.
// A pin transition shows up as a one-cycle rise/fall pulse three clk edges later.
module spi_pin_sync
  import spi_pkg::*;
#(
  parameter int   STAGES      = SPI_SYNC_STAGES,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;
  logic              rise_reg;
  logic              fall_reg;

  // Synchronizer chain, then a registered comparison against the previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RESET_LEVEL}};
      prev_reg <= RESET_LEVEL;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], pin};
      prev_reg <= sync_reg[STAGES-1];
      rise_reg <= sync_reg[STAGES-1] && !prev_reg;
      fall_reg <= !sync_reg[STAGES-1] && prev_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/spi_secondary_tx.sv
// SPI mode-0 secondary transmitter, MSB first, fed through a one-word buffer.
// The next word is loaded on the first falling sck after a word completes, so
// back-to-back words need no gap; an empty buffer at that moment sends FILL_WORD.
module spi_secondary_tx
  import spi_pkg::*;
#(
  parameter int                    WORD_WIDTH = SPI_WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] FILL_WORD  = '0,
  parameter logic                  IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  cs,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  miso,
  output logic                  word_sent,
  output logic                  underrun
);

  localparam int CNT_W = $clog2(WORD_WIDTH + 1);

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;

  spi_pin_sync #(.STAGES(SPI_SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_pin_sync #(.STAGES(SPI_SYNC_STAGES), .RESET_LEVEL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (cs),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  tx_state_t             state;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic [WORD_WIDTH-1:0] buf_reg;
  logic                  buf_full;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  reload;
  logic                  miso_reg;
  logic                  word_sent_reg;
  logic                  underrun_reg;
  logic [WORD_WIDTH-1:0] next_word;

  // Word to load at the next load point: buffered data, or the fill pattern.
  assign next_word = buf_full ? buf_reg : FILL_WORD;

  // Handshake buffer, framing FSM and shifter with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shift_reg     <= '0;
      buf_reg       <= '0;
      buf_full      <= 1'b0;
      bit_cnt       <= '0;
      reload        <= 1'b0;
      miso_reg      <= IDLE_LEVEL;
      word_sent_reg <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      word_sent_reg <= 1'b0;
      underrun_reg  <= 1'b0;

      // Accept only while empty; a load below never coincides with this.
      if (data_valid && !buf_full) begin
        buf_reg  <= data_in;
        buf_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          miso_reg <= IDLE_LEVEL;
          if (cs_fall) begin
            shift_reg <= next_word;
            miso_reg  <= next_word[WORD_WIDTH-1];
            if (buf_full) buf_full <= 1'b0;
            else          underrun_reg <= 1'b1;
            bit_cnt <= '0;
            reload  <= 1'b0;
            state   <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (sck_rise) begin
            if (bit_cnt == CNT_W'(WORD_WIDTH - 1)) begin
              bit_cnt       <= '0;
              word_sent_reg <= 1'b1;
              reload        <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (sck_fall && !cs_rise) begin
            if (reload) begin
              shift_reg <= next_word;
              miso_reg  <= next_word[WORD_WIDTH-1];
              if (buf_full) buf_full <= 1'b0;
              else          underrun_reg <= 1'b1;
              reload <= 1'b0;
            end else begin
              shift_reg <= shift_reg << 1;
              miso_reg  <= shift_reg[WORD_WIDTH-2];
            end
          end

          // Frame end discards any partial word; the buffer is kept.
          if (cs_rise) begin
            miso_reg <= IDLE_LEVEL;
            bit_cnt  <= '0;
            reload   <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign data_ready = !buf_full;
  assign miso       = miso_reg;
  assign word_sent  = word_sent_reg;
  assign underrun   = underrun_reg;

endmodule

// File: tb/tb_spi_secondary_tx.sv
// Directed bench for spi_secondary_tx: acts as the SPI host and the upstream producer.
module tb_spi_secondary_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       miso;
  logic       word_sent;
  logic       underrun;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ws_cnt = 0;
  int ur_cnt = 0;

  spi_secondary_tx #(
    .WORD_WIDTH (8),
    .FILL_WORD  (8'h00),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck        (sck),
    .cs         (cs),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .miso       (miso),
    .word_sent  (word_sent),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (word_sent) ws_cnt <= ws_cnt + 1;
    if (underrun)  ur_cnt <= ur_cnt + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic push_word(input logic [7:0] w);
    bit done = 1'b0;
    @(negedge clk);
    data_in    = w;
    data_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (data_ready) done = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    if (!done) check_vec("push_timeout", 32'd0, 32'd1);
    $display("push: word 0x%02h accepted=%0d", w, done);
  endtask

  task automatic cs_assert();
    @(negedge clk);
    cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Close the frame with sck still high, then return sck to idle low.
  task automatic cs_release();
    cs = 1'b1;
    repeat (6) @(negedge clk);
    sck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Host reads nbits MSB first, sampling miso as it raises sck.
  task automatic read_bits(input int nbits, input bit last_fall, output logic [7:0] w);
    w = '0;
    for (int i = 0; i < nbits; i++) begin
      w   = {w[6:0], miso};
      sck = 1'b1;
      repeat (6) @(negedge clk);
      if (i < nbits - 1 || last_fall) begin
        sck = 1'b0;
        repeat (6) @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] rx, rx2;
    int ws0, ur0;

    // Reset state
    repeat (3) @(negedge clk);
    check_vec("rst_miso", miso, 1);
    check_vec("rst_ready", data_ready, 1);
    check_vec("rst_word_sent", word_sent, 0);
    check_vec("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single word 0xA5
    ws0 = ws_cnt; ur0 = ur_cnt;
    push_word(8'hA5);
    check_vec("a5_ready_low", data_ready, 0);
    cs_assert();
    check_vec("a5_ready_high", data_ready, 1);
    read_bits(8, 1'b0, rx);
    cs_release();
    $display("xfer: expect 0xA5 read 0x%02h", rx);
    check_vec("a5_rx", rx, 8'hA5);
    check_vec("a5_word_sent", ws_cnt - ws0, 1);
    check_vec("a5_underrun", ur_cnt - ur0, 0);
    check_vec("a5_miso_idle", miso, 1);

    // Back-to-back 0x3C then 0xF0
    ws0 = ws_cnt; ur0 = ur_cnt;
    push_word(8'h3C);
    cs_assert();
    push_word(8'hF0);
    check_vec("b2b_ready_low", data_ready, 0);
    read_bits(8, 1'b1, rx);
    read_bits(8, 1'b0, rx2);
    cs_release();
    $display("xfer: expect 0x3C,0xF0 read 0x%02h,0x%02h", rx, rx2);
    check_vec("b2b_rx0", rx, 8'h3C);
    check_vec("b2b_rx1", rx2, 8'hF0);
    check_vec("b2b_word_sent", ws_cnt - ws0, 2);
    check_vec("b2b_underrun", ur_cnt - ur0, 0);
    check_vec("b2b_ready_end", data_ready, 1);

    // Underrun: empty buffer at cs fall
    ws0 = ws_cnt; ur0 = ur_cnt;
    cs_assert();
    check_vec("ur_pulse", ur_cnt - ur0, 1);
    read_bits(8, 1'b0, rx);
    cs_release();
    $display("xfer: underrun fill read 0x%02h", rx);
    check_vec("ur_rx", rx, 8'h00);
    check_vec("ur_word_sent", ws_cnt - ws0, 1);

    // Partial word aborted, then 0x81
    ws0 = ws_cnt; ur0 = ur_cnt;
    push_word(8'hFF);
    cs_assert();
    read_bits(3, 1'b1, rx);
    @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    check_vec("abort_miso_idle", miso, 1);
    repeat (6) @(negedge clk);
    check_vec("abort_rx3", rx, 8'h07);
    check_vec("abort_word_sent", ws_cnt - ws0, 0);
    push_word(8'h81);
    cs_assert();
    read_bits(8, 1'b0, rx);
    cs_release();
    $display("xfer: after abort expect 0x81 read 0x%02h", rx);
    check_vec("abort_next_rx", rx, 8'h81);
    check_vec("abort_next_ws", ws_cnt - ws0, 1);
    check_vec("abort_underrun", ur_cnt - ur0, 0);

    // Asynchronous reset mid-word with a word buffered
    push_word(8'h0F);
    cs_assert();
    push_word(8'hAA);
    check_vec("rstmid_ready_low", data_ready, 0);
    read_bits(2, 1'b1, rx);
    check_vec("rstmid_miso_bit2", miso, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("rstmid_miso", miso, 1);
    check_vec("rstmid_ready", data_ready, 1);
    cs  = 1'b1;
    sck = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    ws0 = ws_cnt; ur0 = ur_cnt;
    cs_assert();
    check_vec("rstmid_underrun", ur_cnt - ur0, 1);
    read_bits(8, 1'b0, rx);
    cs_release();
    $display("xfer: after reset read 0x%02h", rx);
    check_vec("rstmid_rx", rx, 8'h00);

    // sck activity with cs high is ignored; buffer holds its word
    ws0 = ws_cnt; ur0 = ur_cnt;
    @(negedge clk);
    data_in    = 8'h55;
    data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sck = 1'b1;
      repeat (6) @(negedge clk);
      sck = 1'b0;
      repeat (6) @(negedge clk);
      check_vec("csh_miso", miso, 1);
    end
    check_vec("csh_ready_low", data_ready, 0);
    check_vec("csh_word_sent", ws_cnt - ws0, 0);
    check_vec("csh_underrun", ur_cnt - ur0, 0);
    data_valid = 1'b0;
    cs_assert();
    read_bits(8, 1'b0, rx);
    cs_release();
    $display("xfer: retained buffer read 0x%02h", rx);
    check_vec("csh_rx", rx, 8'h55);
    check_vec("csh_final_ur", ur_cnt - ur0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
